fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter STARTING_ADDR, default 32'h01000000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries (legal 2..8).
REQ-003 clock  input  1  single clock; all state on posedge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 mem_address  output  32  byte address presented to main memory.
REQ-006 mem_read_write  output  1  constant 0 (READ).
REQ-007 mem_data_in  output  32  constant 32'h0.
REQ-008 mem_data_out  input  32  instruction word; combinational from mem_address, same cycle.
REQ-009 redirect_valid  input  1  PC redirect request (branch/jump/trap).
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 insn_valid  output  1  buffer head holds an instruction.
REQ-012 insn_ready  input  1  consumer accepts head this cycle.
REQ-013 insn  output  32  head instruction word.
REQ-014 insn_pc  output  32  head instruction address.

Function
REQ-015 FSM states: IDLE, RUN, HALTED; reset enters IDLE; IDLE->RUN unconditionally on the next posedge; no capture in IDLE.
REQ-016 pc register drives mem_address directly; no combinational path from any input to mem_address.
REQ-017 Capture (push) in RUN when buffer count < DEPTH, or count == DEPTH and pop occurs in the same cycle: {pc, mem_data_out} written at buffer tail, pc <= pc + 4.
REQ-018 pc arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-019 Pop when insn_valid && insn_ready; head advances at posedge.
REQ-020 Simultaneous push and pop: count unchanged; when count == 0, data passes through the buffer with one cycle latency (never same cycle).
REQ-021 Full (count == DEPTH) without pop: no push, pc held, mem_address stable.
REQ-022 insn_valid = (count != 0); insn/insn_pc are registered head contents, stable while insn_valid && !insn_ready.
REQ-023 redirect_valid has priority over push and pop: buffer flushed (count <= 0), pc <= {redirect_pc[31:2], 2'b00}, state <= RUN (also from HALTED and IDLE); nothing captured that cycle.
REQ-024 Steady-state throughput: one instruction per cycle when insn_ready held high.

Reset
REQ-025 On reset_n low, asynchronously: pc = STARTING_ADDR, count = 0, head/tail pointers = 0, state = IDLE, insn_valid = 0, insn = 32'h0, insn_pc = 32'h0.
REQ-026 Reset mid-operation discards all buffered instructions; no partial capture survives.

Configuration
REQ-027 Macro FETCH_HALT_EN: when defined, capturing word 32'h00000073 (ECALL) moves RUN->HALTED after the push; HALTED performs no push, pc held, buffered entries still drain; only reset or redirect_valid leaves HALTED.
REQ-028 Without FETCH_HALT_EN: HALTED unreachable; ECALL fetched as any other word.

Structure
REQ-029 Shared package holds: READ/WRITE encodings, STARTING_ADDR default, ECALL encoding, FSM state typedef.
REQ-030 One sub-module, fetch_buffer: DEPTH-entry 64-bit circular FIFO with push, pop, flush, count; fetch_unit holds FSM and pc.

Verification
REQ-031 Reset release, insn_ready=1, memory holds 13,17,19... at 32'h01000000+: first insn_valid at cycle 2 after release, insn_pc 32'h01000000, then +4 each cycle.
REQ-032 insn_ready=0 for 5 cycles: count reaches 2, mem_address holds 32'h01000008, insn/insn_pc unchanged; release -> no word skipped or duplicated.
REQ-033 redirect_valid with redirect_pc=32'h01000043 while buffer full: next cycle insn_valid=0, mem_address=32'h01000040; following cycle insn_pc=32'h01000040.
REQ-034 FETCH_HALT_EN, ECALL at 32'h01000010: last insn_pc 32'h01000010, mem_address stuck at 32'h01000014; redirect to 32'h01000000 resumes fetch.
REQ-035 Redirect to 32'hFFFFFFFC: insn_pc sequence 32'hFFFFFFFC then 32'h00000000.
REQ-036 reset_n pulsed low between clocks with 2 entries buffered: insn_valid falls immediately; fetch restarts at STARTING_ADDR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: memory command
// encodings, reset fetch address, ECALL encoding, FSM state type and
// the instruction buffer entry layout.
package fetch_unit_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] DEFAULT_STARTING_ADDR = 32'h0100_0000;
  localparam logic [31:0] ECALL                 = 32'h0000_0073;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

  // One buffered instruction: its address and the fetched word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry circular FIFO of {pc, insn} records. Flush wins over push/pop.
// Head is read straight out of the storage registers, so a pushed entry is
// visible one cycle after the push, never in the same cycle.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head_ptr, tail_ptr;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= next_ptr(tail_ptr);
      if (pop)  head_ptr <= next_ptr(head_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[tail_ptr] <= push_data;
    end
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: pc register + IDLE/RUN/HALTED FSM feeding a small
// instruction buffer. mem_address comes only from the pc register.
// Optional feature macro: FETCH_HALT_EN (halt fetch after capturing ECALL).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR = DEFAULT_STARTING_ADDR,
  parameter int          DEPTH         = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic          push, pop;
  fetch_entry_t  head, tail_entry;

  // Redirect targets are word aligned; the low bits are dropped on purpose.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign insn_valid = (count != '0);
  // Redirect suppresses both buffer operations in its cycle.
  assign pop  = insn_valid && insn_ready && !redirect_valid;
  assign push = (state == ST_RUN) && !redirect_valid &&
                ((count < CW'(DEPTH)) || pop);

  assign tail_entry.pc   = pc;
  assign tail_entry.insn = mem_data_out;

  // FSM and pc: redirect overrides everything, otherwise advance on capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pc    <= STARTING_ADDR;
    end else if (redirect_valid) begin
      state <= ST_RUN;
      pc    <= {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) pc <= pc + 32'd4;
      if (state == ST_IDLE) state <= ST_RUN;
`ifdef FETCH_HALT_EN
      else if (push && mem_data_out == ECALL) state <= ST_HALTED;
`endif
    end
  end

  fetch_buffer #(.DEPTH(DEPTH), .CW(CW)) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (tail_entry),
    .head      (head),
    .count     (count)
  );

  assign mem_address    = pc;
  assign mem_read_write = READ;
  assign mem_data_in    = '0;
  assign insn           = head.insn;
  assign insn_pc        = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam logic [31:0] ECALL_W = 32'h0000_0073;

  logic        clock, reset_n;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic        redirect_valid, insn_valid, insn_ready;
  logic [31:0] redirect_pc, insn, insn_pc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.STARTING_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn           (insn),
    .insn_pc        (insn_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory image: primes in the first 16 words, address-derived elsewhere
  // (low bits 2'b10 so it can never look like ECALL).
  logic [31:0] primes [16] = '{32'd13, 32'd17, 32'd19, 32'd23, 32'd29, 32'd31,
                               32'd37, 32'd41, 32'd43, 32'd47, 32'd53, 32'd59,
                               32'd61, 32'd67, 32'd71, 32'd79};

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
`ifdef FETCH_HALT_EN
    if (a == BASE + 32'h10) return ECALL_W;
`endif
    if (off < 32'h40) return primes[off[5:2]];
    return {a[29:0], 2'b10};
  endfunction

  always_comb mem_data_out = word_at(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_mode;  // 0 idle, 1 fetching, 2 halted

  task automatic model_reset();
    mq.delete();
    m_pc   = BASE;
    m_mode = 0;
  endtask

  task automatic model_step(input logic rd, input logic [31:0] rpc, input logic rdy);
    bit   do_pop, do_push;
    ent_t e;
    if (rd) begin
      mq.delete();
      m_pc   = rpc & 32'hFFFF_FFFC;
      m_mode = 1;
      return;
    end
    do_pop  = (mq.size() != 0) && rdy;
    do_push = (m_mode == 1) && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.pc = m_pc;
      e.w  = word_at(m_pc);
      mq.push_back(e);
      m_pc = m_pc + 32'd4;
`ifdef FETCH_HALT_EN
      if (e.w == ECALL_W) m_mode = 2;
`endif
    end
    if (m_mode == 0) m_mode = 1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;
  vec_t tv[12];

  initial begin
    // Held ready low: buffer fills to 2 with mem_address parked at +8,
    // then drains in order; a redirect on a full buffer flushes it.
    tv[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         BASE};
    tv[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, BASE,          BASE + 32'h4};
    tv[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, BASE,          BASE + 32'h8};
    tv[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, BASE,          BASE + 32'h8};
    tv[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, BASE,          BASE + 32'h8};
    tv[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, BASE,          BASE + 32'h8};
    tv[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, BASE + 32'h4,  BASE + 32'hC};
    tv[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, BASE + 32'h8,  BASE + 32'h10};
    tv[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, BASE + 32'h8,  BASE + 32'h10};
    tv[9]  = '{1'b1, 1'b1, 32'h0100_0043, 1'b0, 32'h0,         BASE + 32'h40};
    tv[10] = '{1'b1, 1'b0, 32'h0,         1'b1, BASE + 32'h40, BASE + 32'h44};
    tv[11] = '{1'b1, 1'b0, 32'h0,         1'b1, BASE + 32'h44, BASE + 32'h48};

    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; insn_ready = 1'b0;
    #12;
    chk("reset insn_valid", {31'b0, insn_valid}, 32'h0);
    chk("reset insn", insn, 32'h0);
    chk("reset insn_pc", insn_pc, 32'h0);
    chk("reset mem_address", mem_address, BASE);
    chk("mem_read_write", {31'b0, mem_read_write}, 32'h0);
    chk("mem_data_in", mem_data_in, 32'h0);

    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      insn_ready = tv[i].rdy; redirect_valid = tv[i].rd; redirect_pc = tv[i].rpc;
      @(negedge clock);
      chk($sformatf("tbl%0d valid", i), {31'b0, insn_valid}, {31'b0, tv[i].ev});
      chk($sformatf("tbl%0d mem_address", i), mem_address, tv[i].eaddr);
      if (tv[i].ev) begin
        chk($sformatf("tbl%0d insn_pc", i), insn_pc, tv[i].epc);
        chk($sformatf("tbl%0d insn", i), insn, word_at(tv[i].epc));
      end
    end
    redirect_valid = 1'b0;

    // pc wraps modulo 2^32
    insn_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    chk("wrap flush valid", {31'b0, insn_valid}, 32'h0);
    chk("wrap mem_address", mem_address, 32'hFFFF_FFFC);
    @(negedge clock);
    chk("wrap pc0", insn_pc, 32'hFFFF_FFFC);
    chk("wrap addr0", mem_address, 32'h0);
    @(negedge clock);
    chk("wrap pc1", insn_pc, 32'h0);
    chk("wrap insn1", insn, word_at(32'h0));

    // Asynchronous reset with two entries buffered
    insn_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = BASE + 32'h20;
    @(negedge clock);
    redirect_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre-reset full addr", mem_address, BASE + 32'h28);
    chk("pre-reset valid", {31'b0, insn_valid}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset valid", {31'b0, insn_valid}, 32'h0);
    chk("async reset addr", mem_address, BASE);
    chk("async reset insn", insn, 32'h0);
    @(negedge clock);
    reset_n = 1'b1; insn_ready = 1'b1;
    @(negedge clock);
    chk("restart idle valid", {31'b0, insn_valid}, 32'h0);
    @(negedge clock);
    chk("restart insn_pc", insn_pc, BASE);
    chk("restart insn", insn, 32'd13);

`ifdef FETCH_HALT_EN
    begin
      logic [31:0] last_pc;
      last_pc = '0;
      reset_n = 1'b0; #1; @(negedge clock); reset_n = 1'b1; insn_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
        @(negedge clock);
        if (insn_valid) last_pc = insn_pc;
      end
      chk("halt last insn_pc", last_pc, BASE + 32'h10);
      chk("halt mem_address", mem_address, BASE + 32'h14);
      chk("halt drained", {31'b0, insn_valid}, 32'h0);
      redirect_valid = 1'b1; redirect_pc = BASE;
      @(negedge clock);
      redirect_valid = 1'b0;
      @(negedge clock);
      chk("halt resume insn_pc", insn_pc, BASE);
    end
`endif

    // Randomized run against the reference model
    reset_n = 1'b0; insn_ready = 1'b0; redirect_valid = 1'b0; #1;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      insn_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = BASE + ($urandom_range(0, 63));
        1:       redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: redirect_pc = $urandom;
      endcase
      model_step(redirect_valid, redirect_pc, insn_ready);
      @(negedge clock);
      chk($sformatf("rnd%0d valid", c), {31'b0, insn_valid}, {31'b0, mq.size() != 0});
      chk($sformatf("rnd%0d mem_address", c), mem_address, m_pc);
      if (mq.size() != 0) begin
        chk($sformatf("rnd%0d insn_pc", c), insn_pc, mq[0].pc);
        chk($sformatf("rnd%0d insn", c), insn, mq[0].w);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
